// File: rtl/plab1_imul_zero_scanner_pkg.sv
// Shared definitions for the trailing-zero scanner: FSM state encoding,
// default geometry and the count-width helper used for port sizing.
package plab1_imul_zero_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_W     = 32;
    localparam int DEFAULT_CHUNK = 8;

    // Bits needed to hold any value 0..w inclusive.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/plab1_imul_zero_scanner_chunk_ctz.sv
// Combinational trailing-zero counter for one CHUNK-bit slice.
// An all-zero slice reports CHUNK so the caller can tell "no set bit here".
module plab1_imul_zero_scanner_chunk_ctz
    import plab1_imul_zero_scanner_pkg::*;
#(
    parameter  int CHUNK = DEFAULT_CHUNK,
    localparam int CTZW  = count_width(CHUNK)
) (
    input  logic [CHUNK-1:0] chunk_i,
    output logic [CTZW-1:0]  ctz_o
);

    // Priority search from MSB down so the lowest set bit wins last.
    always_comb begin
        ctz_o = CTZW'(CHUNK);
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk_i[i]) begin
                ctz_o = CTZW'(i);
            end
        end
    end

endmodule

// File: rtl/plab1_imul_zero_scanner.sv
// Multi-cycle trailing-zero counter: examines CHUNK bits of the operand per
// SCAN cycle, stopping at the first non-zero chunk, with a valid/ready
// result port carrying the request's security-domain tag.
// Optional build macro PLAB1_IMUL_ZERO_SCANNER_EARLY_EXIT_EN: finish the scan
// as soon as the remaining operand register is entirely zero.
module plab1_imul_zero_scanner
    import plab1_imul_zero_scanner_pkg::*;
#(
    parameter  int W     = DEFAULT_W,
    parameter  int CHUNK = DEFAULT_CHUNK,
    localparam int CW    = count_width(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_val,
    output logic          in_rdy,
    input  logic [W-1:0]  in_operand,
    input  logic          in_sd,
    output logic          out_val,
    input  logic          out_rdy,
    output logic [CW-1:0] out_count,
    output logic          out_zero,
    output logic          out_sd
);

    localparam int CTZW = count_width(CHUNK);

    state_e          state_q, state_d;
    logic [W-1:0]    operand_q, operand_d;
    logic [CW-1:0]   count_q, count_d;
    logic            zero_q, zero_d;
    logic            sd_q, sd_d;

    logic [CTZW-1:0] chunk_ctz;
    logic            chunk_nz;
    logic            last_chunk;
    logic            remaining_zero;
    // One extra bit so count + CHUNK can never wrap before the compare.
    logic [CW:0]     count_plus_chunk;

    plab1_imul_zero_scanner_chunk_ctz #(
        .CHUNK (CHUNK)
    ) u_chunk_ctz (
        .chunk_i (operand_q[CHUNK-1:0]),
        .ctz_o   (chunk_ctz)
    );

    assign chunk_nz         = (operand_q[CHUNK-1:0] != '0);
    assign count_plus_chunk = {1'b0, count_q} + (CW+1)'(CHUNK);
    assign last_chunk       = (count_plus_chunk >= (CW+1)'(W));

`ifdef PLAB1_IMUL_ZERO_SCANNER_EARLY_EXIT_EN
    assign remaining_zero = (operand_q == '0);
`else
    assign remaining_zero = 1'b0;
`endif

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept, scan until a set bit or the end, then hand off.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_val) state_d = ST_SCAN;
            ST_SCAN: if (remaining_zero || chunk_nz || last_chunk) state_d = ST_DONE;
            ST_DONE: if (out_rdy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from state.
    always_comb begin
        in_rdy  = (state_q == ST_IDLE);
        out_val = (state_q == ST_DONE);
    end

    // Datapath next-state: capture on accept, shift/accumulate while scanning.
    always_comb begin
        operand_d = operand_q;
        count_d   = count_q;
        zero_d    = zero_q;
        sd_d      = sd_q;
        case (state_q)
            ST_IDLE: begin
                if (in_val) begin
                    operand_d = in_operand;
                    sd_d      = in_sd;
                    count_d   = '0;
                    zero_d    = 1'b0;
                end
            end
            ST_SCAN: begin
                if (remaining_zero) begin
                    count_d = CW'(W);
                    zero_d  = 1'b1;
                end else if (chunk_nz) begin
                    count_d = count_q + CW'(chunk_ctz);
                    zero_d  = 1'b0;
                end else if (last_chunk) begin
                    count_d = CW'(W);
                    zero_d  = 1'b1;
                end else begin
                    operand_d = operand_q >> CHUNK;
                    count_d   = count_plus_chunk[CW-1:0];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; results clear on reset so nothing stale is visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            operand_q <= '0;
            count_q   <= '0;
            zero_q    <= 1'b0;
            sd_q      <= 1'b0;
        end else begin
            operand_q <= operand_d;
            count_q   <= count_d;
            zero_q    <= zero_d;
            sd_q      <= sd_d;
        end
    end

    assign out_count = count_q;
    assign out_zero  = zero_q;
    assign out_sd    = sd_q;

endmodule

// File: doc/plab1_imul_zero_scanner.md
PLAB1_IMUL_ZERO_SCANNER -- requirements
Module: plab1_imul_ZeroScanner

Interface
REQ-001 Parameter W, default 32: operand width in bits; SHALL be a multiple of CHUNK and at least CHUNK.
REQ-002 Parameter CHUNK, default 8: bits examined per SCAN cycle; SHALL be a power of two, 2 to 16.
REQ-003 Derived constant CW = clog2(W+1): width of the count output.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_val  input  1  request valid.
REQ-007 in_rdy  output  1  block can accept a request.
REQ-008 in_operand  input  W  value whose trailing zeros are counted.
REQ-009 in_sd  input  1  security-domain tag of the request.
REQ-010 out_val  output  1  result valid.
REQ-011 out_rdy  input  1  consumer accepts result.
REQ-012 out_count  output  CW  number of trailing zeros (W if operand is zero).
REQ-013 out_zero  output  1  operand was all zeros.
REQ-014 out_sd  output  1  security-domain tag captured with the request.

Function
REQ-015 FSM states IDLE, SCAN, DONE; in_rdy SHALL be 1 only in IDLE; out_val SHALL be 1 only in DONE.
REQ-016 IDLE, in_val=1: operand and in_sd latched, count register cleared, next state SCAN; in_val=0: stay IDLE.
REQ-017 SCAN, each cycle: low CHUNK bits of operand register examined by the chunk counter.
REQ-018 SCAN, chunk nonzero: count <= count + trailing zeros of chunk, out_zero <= 0, next state DONE.
REQ-019 SCAN, chunk zero, count+CHUNK < W: operand shifted right by CHUNK, count <= count + CHUNK, stay SCAN.
REQ-020 SCAN, chunk zero, count+CHUNK = W: count <= W, out_zero <= 1, next state DONE.
REQ-021 Latency: lowest set bit in chunk k (0-based) SHALL reach DONE k+1 edges after the accepting edge.
REQ-022 DONE: out_count, out_zero, out_sd held stable until out_rdy=1; handshake edge moves to IDLE.
REQ-023 No accept in the cycle a result drains; the next request is accepted no earlier than the following IDLE cycle.
REQ-024 in_operand and in_sd SHALL be ignored outside IDLE; no internal arithmetic SHALL overflow CW bits.
REQ-025 out_count and out_sd SHALL carry the domain of the captured in_sd; no result from a prior request is visible after a new accept.

Reset
REQ-026 reset=1 forces IDLE immediately, regardless of clock: in_rdy=1, out_val=0, out_count=0, out_zero=0, out_sd=0.
REQ-027 Reset during SCAN or DONE SHALL discard the transaction; no out_val pulse after reset deasserts.

Configuration
REQ-028 Macro PLAB1_IMUL_ZERO_SCANNER_EARLY_EXIT_EN defined: in SCAN, if the entire remaining operand register is zero, count <= W, out_zero <= 1, next state DONE in that cycle.
REQ-029 Macro undefined: no early exit; a zero operand takes exactly W/CHUNK SCAN cycles; nonzero timing is identical in both builds.

Structure
REQ-030 Shared plab1_imul package/header SHALL hold FSM state encodings and the CW width function.
REQ-031 One sub-module plab1_imul_ChunkCtz: combinational CHUNK-bit trailing-zero count, returns CHUNK on zero input.
REQ-032 Datapath (operand shift register, count register, result registers) and FSM live in the top module.

Verification (W=32, CHUNK=8)
REQ-033 Operand 0x00000001 -> out_count=0, out_zero=0, out_val 1 edge after accept.
REQ-034 Operand 0x00010000 -> out_count=16 after 3 SCAN edges; 0x80000000 -> out_count=31 after 4 SCAN edges.
REQ-035 Operand 0x00000000 -> out_count=32, out_zero=1; 4 SCAN edges without macro, 1 with macro.
REQ-036 out_rdy held 0 for 5 cycles in DONE -> outputs stable, in_rdy=0 throughout; IDLE on the edge after out_rdy=1.
REQ-037 reset asserted mid-SCAN for operand 0x01000000 -> out_val=0 and in_rdy=1 immediately; next request 0x4 -> out_count=2.
REQ-038 Back-to-back requests with in_sd=1 then 0 -> each out_sd matches its own request, in order.
